// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO multiply/divide unit for a MIPS-style pipeline.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract.
// Both run 32 iterations on operand magnitudes, then one FIX cycle applies signs.
// MTHI/MTLO write HI/LO directly when the unit is idle.
// Optional build macro: MULDIV_FAST_ZERO_EN. When defined, a zero multiply operand
// or a zero divisor skips the iteration phase and goes straight to FIX.
module muldiv_ctrl #(
    parameter int DATA_W = 32  // only 32 is supported
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [5:0]        i_function,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    input  logic              i_mf_req,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_stall
);

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Control state
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;

    // Architectural registers
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    // Iteration datapath.
    // Multiply: r_acc is the running high half and r_q holds the multiplier
    // (it becomes the low half). r_opb is the multiplicand.
    // Divide: r_acc is the partial remainder and r_q holds the dividend
    // (it becomes the quotient). r_opb is the divisor.
    // r_acc has one extra bit for the carry or borrow.
    logic [DATA_W:0]   r_acc;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_a;       // raw dividend, returned as HI on divide-by-zero
    logic              r_is_div;
    logic              r_neg_q;   // negate product / quotient in FIX
    logic              r_neg_r;   // negate remainder in FIX
    logic              r_zero;    // zero multiply operand or zero divisor

    // Request decode
    logic              w_fn_mul;
    logic              w_fn_div;
    logic              w_fn_muldiv;
    logic              w_fn_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic              w_zero_op;
    logic              w_skip;

    // One iteration step
    logic [DATA_W:0]   w_mul_sum;
    logic [DATA_W:0]   w_mul_sel;
    logic [2*DATA_W:0] w_mul_shift;
    logic [DATA_W:0]   w_div_shift;
    logic [DATA_W:0]   w_div_diff;
    logic              w_div_ge;

    // Sign-corrected results written in FIX
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    // Decode the request and form operand magnitudes for the signed ops
    always_comb begin
        w_fn_mul    = (i_function == FN_MULT) || (i_function == FN_MULTU);
        w_fn_div    = (i_function == FN_DIV)  || (i_function == FN_DIVU);
        w_fn_muldiv = w_fn_mul || w_fn_div;
        w_fn_signed = (i_function == FN_MULT) || (i_function == FN_DIV);
        w_a_neg     = w_fn_signed & i_op_a[DATA_W-1];
        w_b_neg     = w_fn_signed & i_op_b[DATA_W-1];
        w_a_mag     = w_a_neg ? -i_op_a : i_op_a;
        w_b_mag     = w_b_neg ? -i_op_b : i_op_b;
        w_zero_op   = w_fn_div ? (i_op_b == '0) : ((i_op_a == '0) || (i_op_b == '0));
    end

`ifdef MULDIV_FAST_ZERO_EN
    assign w_skip = w_zero_op;
`else
    assign w_skip = 1'b0;
`endif

    // Compute one shift-add or one restoring shift-subtract step
    always_comb begin
        w_mul_sum   = r_acc + {1'b0, r_opb};
        w_mul_sel   = r_q[0] ? w_mul_sum : r_acc;
        w_mul_shift = {w_mul_sel, r_q} >> 1;
        w_div_shift = {r_acc[DATA_W-1:0], r_q[DATA_W-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        // The remainder stays below the divisor, so bit DATA_W acts as the borrow
        w_div_ge    = ~w_div_diff[DATA_W];
    end

    // Apply sign correction and the zero special cases to form the HI/LO result
    always_comb begin
        w_prod   = {r_acc[DATA_W-1:0], r_q};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_quot   = r_neg_q ? -r_q : r_q;
        w_rem    = r_neg_r ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_is_div) begin
            if (r_zero) begin
                w_res_lo = '1;
                w_res_hi = r_a;
            end else begin
                w_res_lo = w_quot;
                w_res_hi = w_rem;
            end
        end else if (!r_zero) begin
            w_res_hi = w_prod_s[2*DATA_W-1:DATA_W];
            w_res_lo = w_prod_s[DATA_W-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers, with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opb    <= '0;
            r_a      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (w_fn_muldiv) begin
                            r_acc    <= '0;
                            r_q      <= w_a_mag;
                            r_opb    <= w_b_mag;
                            r_a      <= i_op_a;
                            r_is_div <= w_fn_div;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_zero   <= w_zero_op;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= w_skip ? FIX : ITER;
                        end else if (i_function == FN_MTHI) begin
                            r_hi <= i_op_a;
                        end else if (i_function == FN_MTLO) begin
                            r_lo <= i_op_a;
                        end
                    end
                end
                ITER: begin
                    if (r_is_div) begin
                        r_acc <= w_div_ge ? w_div_diff : w_div_shift;
                        r_q   <= {r_q[DATA_W-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_shift[2*DATA_W:DATA_W];
                        r_q   <= w_mul_shift[DATA_W-1:0];
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == '1) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_stall = r_busy & (i_start | i_mf_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time unit later.
// "Cycle n" is the interval after the n-th edge counted from the start cycle.
module tb_muldiv_ctrl;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [5:0]  i_function;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        i_mf_req;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_done;
    logic        o_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.DATA_W(32)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_function (i_function),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .i_mf_req   (i_mf_req),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_stall    (o_stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one multiply/divide and check busy, stall, done and the result.
    // hold_mf holds i_mf_req from the start cycle through the done cycle.
    // mthi_cyc, if positive, issues an MTHI in that busy cycle.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit hold_mf, input int mthi_cyc);
        int lat;
        bit ok_busy;
        bit ok_stall;
        lat = 34;
`ifdef MULDIV_FAST_ZERO_EN
        if (b == 32'd0 || ((fn == FN_MULT || fn == FN_MULTU) && a == 32'd0)) lat = 2;
`endif
        ok_busy  = 1'b1;
        ok_stall = 1'b1;
        i_function = fn;
        i_op_a     = a;
        i_op_b     = b;
        i_start    = 1'b1;
        i_mf_req   = hold_mf;
        #1;
        chk({tag, "_stall_c0"}, {31'd0, o_stall}, 32'd0);
        tick;
        i_start = 1'b0;
        i_op_a  = $urandom;
        i_op_b  = $urandom;
        for (int c = 1; c < lat; c++) begin
            if (c == mthi_cyc) begin
                i_start    = 1'b1;
                i_function = FN_MTHI;
                i_op_a     = 32'hDEADBEEF;
            end
            #1;
            if (o_busy !== 1'b1 || o_done !== 1'b0) ok_busy = 1'b0;
            if (o_stall !== (hold_mf || c == mthi_cyc)) ok_stall = 1'b0;
            tick;
            i_start = 1'b0;
        end
        #1;
        chk({tag, "_busy_win"},  {31'd0, ok_busy},  32'd1);
        chk({tag, "_stall_win"}, {31'd0, ok_stall}, 32'd1);
        chk({tag, "_done"},      {31'd0, o_done},   32'd1);
        chk({tag, "_busy_end"},  {31'd0, o_busy},   32'd0);
        chk({tag, "_stall_end"}, {31'd0, o_stall},  32'd0);
        chk({tag, "_hi"}, o_hi, exp_hi);
        chk({tag, "_lo"}, o_lo, exp_lo);
        i_mf_req = 1'b0;
        tick;
        chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin : stim
        bit ok;
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_function = 6'h00;
        i_op_a     = 32'd0;
        i_op_b     = 32'd0;
        i_mf_req   = 1'b0;
        tick;
        // Reset has priority over a simultaneous start
        i_start    = 1'b1;
        i_function = FN_MULT;
        i_op_a     = 32'd9;
        i_op_b     = 32'd9;
        tick;
        i_start = 1'b0;
        chk("rst_hi",    o_hi, 32'd0);
        chk("rst_lo",    o_lo, 32'd0);
        chk("rst_busy",  {31'd0, o_busy},  32'd0);
        chk("rst_done",  {31'd0, o_done},  32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        i_rst = 1'b0;
        tick;
        chk("rst_rel_busy", {31'd0, o_busy}, 32'd0);

        run_op("mult_m2x3",   FN_MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, -1);
        run_op("multu_m2x3",  FN_MULTU, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 0, -1);
        run_op("div_m7d2",    FN_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, -1);
        run_op("div_7dm2",    FN_DIV,   32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, -1);
        run_op("divu_7d0",    FN_DIVU,  32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF, 0, -1);
        run_op("div_m7d0",    FN_DIV,   32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, -1);
        run_op("div_ovf",     FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, -1);

        // MTLO in idle with an MFxx in decode: no stall, old LO visible this cycle
        i_start    = 1'b1;
        i_function = FN_MTLO;
        i_op_a     = 32'h12345678;
        i_mf_req   = 1'b1;
        #1;
        chk("mtlo_stall_c0", {31'd0, o_stall}, 32'd0);
        chk("mtlo_lo_pre",   o_lo, 32'h80000000);
        tick;
        i_start  = 1'b0;
        i_mf_req = 1'b0;
        chk("mtlo_lo",   o_lo, 32'h12345678);
        chk("mtlo_hi",   o_hi, 32'h0);
        chk("mtlo_done", {31'd0, o_done}, 32'd0);
        chk("mtlo_busy", {31'd0, o_busy}, 32'd0);
        i_start    = 1'b1;
        i_function = FN_MTHI;
        i_op_a     = 32'hCAFEF00D;
        tick;
        i_start = 1'b0;
        chk("mthi_hi",   o_hi, 32'hCAFEF00D);
        chk("mthi_lo",   o_lo, 32'h12345678);
        chk("mthi_done", {31'd0, o_done}, 32'd0);

        // MTHI issued in busy cycle 5 must be dropped
        run_op("mult_mthi", FN_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 5);
        // MFxx held across a DIVU: stall exactly in cycles 1..33
        run_op("divu_stall", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1, -1);

        // Unknown function code is ignored
        i_start    = 1'b1;
        i_function = 6'h3f;
        i_op_a     = 32'h11111111;
        i_op_b     = 32'h22222222;
        tick;
        i_start = 1'b0;
        chk("bad_fn_busy", {31'd0, o_busy}, 32'd0);
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (o_busy !== 1'b0 || o_done !== 1'b0) ok = 1'b0;
            tick;
        end
        chk("bad_fn_quiet", {31'd0, ok}, 32'd1);
        chk("bad_fn_hi", o_hi, 32'd2);
        chk("bad_fn_lo", o_lo, 32'd14);

        // Reset in cycle 10 of a MULTU aborts it with no done pulse
        i_start    = 1'b1;
        i_function = FN_MULTU;
        i_op_a     = 32'hFFFFFFFF;
        i_op_b     = 32'hFFFFFFFF;
        tick;
        i_start = 1'b0;
        for (int c = 1; c < 10; c++) tick;
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_hi",   o_hi, 32'd0);
        chk("abort_lo",   o_lo, 32'd0);
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (o_done !== 1'b0 || o_busy !== 1'b0) ok = 1'b0;
            tick;
        end
        chk("abort_no_done", {31'd0, ok}, 32'd1);

        run_op("multu_3x5",  FN_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0, -1);
        run_op("multu_0x",   FN_MULTU, 32'd0, 32'h1234, 32'd0, 32'd0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
